prio_arbiter: RTL and testbench

Parametrised N-input registered priority arbiter with a valid/ack grant handshake and a runtime-selectable fixed-priority or round-robin mode. It generalises the team's registered 4-bit priority encoder: any request width, a one-hot and binary grant, and a grant held stable until the consumer accepts it. It sits in front of shared resources such as a bus port or buffer write port, where several requesters compete.

---
 rtl/prio_arbiter_pkg.sv | 9 +
 rtl/prio_pick.sv | 16 +
 rtl/prio_arbiter.sv | 73 +++++++
 tb/tb_prio_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_pkg.sv
// prio_arbiter_pkg: shared state and mode encodings for the priority arbiter
package prio_arbiter_pkg;
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;
    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;
endpackage

// File: rtl/prio_pick.sv
// prio_pick: index of the lowest set bit of vec, plus an any-set flag
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
    end
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way fixed/round-robin arbiter with ack handshake; PRIO_ARBITER_TIMEOUT_EN adds grant timeout
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int TIMEOUT = 16,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         timeout
);
    if (N < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("prio_arbiter: N and TIMEOUT must be >= 2");
    end

    arb_state_t   state, state_nxt;
    logic [W-1:0] p, p_nxt, nxt_ptr, m_idx, u_idx, win;
    logic [N-1:0] masked;
    logic         m_any, u_any, expire, release_g, arb;

`ifdef PRIO_ARBITER_TIMEOUT_EN
    localparam int WT = $clog2(TIMEOUT + 1);
    logic [WT-1:0] wcnt;
    assign expire = state == ARB_GRANT && !ack && wcnt == WT'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) wcnt <= '0;
        else      wcnt <= arb ? '0 : wcnt + 1'b1;
`else
    assign expire = 1'b0;
`endif

    // the pointer used for this edge's arbitration already reflects the release
    always_comb begin
        release_g = state == ARB_GRANT && (ack || expire);
        arb       = state == ARB_IDLE || release_g;
        nxt_ptr   = gnt_idx == W'(N - 1) ? '0 : gnt_idx + 1'b1;
        p_nxt     = release_g && mode == ARB_MODE_RR ? nxt_ptr : p;
        masked    = req & ~((N'(1) << p_nxt) - N'(1));
        win       = mode == ARB_MODE_RR && m_any ? m_idx : u_idx;
        state_nxt = arb ? (u_any ? ARB_GRANT : ARB_IDLE) : state;
    end

    prio_pick #(.N(N)) u_masked (.vec(masked), .idx(m_idx), .any(m_any));
    prio_pick #(.N(N)) u_plain  (.vec(req),    .idx(u_idx), .any(u_any));

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ARB_IDLE;
        else      state <= state_nxt;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            p          <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
        end else begin
            p       <= p_nxt;
            timeout <= expire;
            if (arb) begin
                gnt_valid  <= u_any;
                gnt_onehot <= u_any ? N'(1) << win : '0;
                if (u_any) gnt_idx <= win;
            end
        end
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: scoreboard bench for prio_arbiter against a cyclic-search reference model
module tb_prio_arbiter;
    localparam int N = 8;
    localparam int W = 3;
    localparam int TIMEOUT = 16;
`ifdef PRIO_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b0, mode = 1'b0, ack = 1'b0;
    logic [N-1:0] req = '0;
    logic         gnt_valid, timeout;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;

    prio_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .ack(ack),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] idx;
        logic [N-1:0] oh;
        logic         to;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int vectors = 0, miscompares = 0;
    bit mv = 1'b0;
    int midx = 0, mp = 0, mwait = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p, input logic rr);
        int s = rr ? p : 0;
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic arbitrate(input logic [N-1:0] r, input logic md);
        int w = pick(r, mp, md);
        if (w < 0) mv = 1'b0;
        else begin
            mv = 1'b1;
            midx = w;
            mwait = 0;
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic md, input logic a);
        exp_t e;
        bit to = 1'b0;
        @(negedge clk);
        req = r; mode = md; ack = a;
        if (!mv) arbitrate(r, md);
        else if (a || (TO_EN && mwait == TIMEOUT - 1)) begin
            to = !a;
            if (md) mp = (midx + 1) % N;
            arbitrate(r, md);
        end else mwait++;
        e.v = mv; e.idx = midx[W-1:0]; e.oh = mv ? N'(1) << midx : '0; e.to = to;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            check("mon_valid", gnt_valid, e_mon.v);
            check("mon_onehot", gnt_onehot, e_mon.oh);
            check("mon_timeout", timeout, e_mon.to);
            if (e_mon.v) check("mon_idx", gnt_idx, e_mon.idx);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, gnt_valid, 0);
        check({tag, "_idx"}, gnt_idx, 0);
        check({tag, "_onehot"}, gnt_onehot, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        // fixed priority: lowest set bit wins and holds until ack
        cyc(8'hA8, 0, 0);
        check("fix_idx", gnt_idx, 3);
        check("fix_onehot", gnt_onehot, 8'h08);
        repeat (5) cyc(8'hA8, 0, 0);
        check("fix_hold", gnt_idx, 3);
        cyc(8'hA8, 0, 1);
        check("fix_regrant", gnt_idx, 3);
        cyc(8'h00, 0, 1);
        check("fix_idle", gnt_valid, 0);
        // round-robin sweep with no bubbles
        cyc(8'hFF, 1, 0);
        check("rr_first", gnt_idx, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(8'hFF, 1, 1);
            check("rr_sweep", gnt_idx, i % 8);
        end
        cyc(8'h00, 1, 1);
        // wrap: p=6 then p=1
        cyc(8'h20, 1, 0);
        check("rr_g5", gnt_idx, 5);
        cyc(8'h21, 1, 1);
        check("rr_wrap0", gnt_idx, 0);
        cyc(8'h21, 1, 1);
        check("rr_wrap5", gnt_idx, 5);
        cyc(8'h00, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(8'h00, 1, i[0]);
            check("idle_ack_valid", gnt_valid, 0);
        end
        cyc(8'hFF, 1, 0);
        check("ptr_kept", gnt_idx, 6);
        cyc(8'h00, 1, 1);
        // grant wait with and without expiry
        cyc(8'h0C, 1, 0);
        check("to_g2", gnt_idx, 2);
        repeat (15) cyc(8'h0C, 1, 0);
        cyc(8'h0C, 1, 0);
`ifdef PRIO_ARBITER_TIMEOUT_EN
        check("to_pulse", timeout, 1);
        check("to_next", gnt_idx, 3);
`else
        check("to_none", timeout, 0);
        check("to_held", gnt_idx, 2);
`endif
        repeat (15) cyc(8'h0C, 1, 0);
        cyc(8'h0C, 1, 1);
        check("to_ack_wins", timeout, 0);
        cyc(8'h00, 1, 1);
        // asynchronous reset mid-grant
        cyc(8'h10, 0, 0);
        check("rst_pre", gnt_idx, 4);
        rst = 1'b0;
        #1;
        check_zero("rst_async");
        mv = 1'b0; midx = 0; mp = 0; mwait = 0;
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        cyc(8'h00, 0, 0);
        check("rst_after", gnt_valid, 0);
        repeat (500)
            cyc(N'($urandom & $urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
